// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the sram-like port arbiter: owner tags, transfer size, lock states.
package sram_arbiter_pkg;

    localparam logic       OWNER_INST = 1'b0;
    localparam logic       OWNER_DATA = 1'b1;
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sram_arbiter_owner_fifo.sv
// In-order owner tag FIFO: remembers which requester each accepted request belongs to.
module sram_arbiter_owner_fifo
    import sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter onto one sram-like port: data side wins, grant held through a stalled handshake.
//
// state     | meaning
// ST_IDLE   | no pending handshake; grant data if requesting, else inst
// ST_LOCK_I | inst request presented but not yet accepted; grant pinned to inst
// ST_LOCK_D | data request presented but not yet accepted; grant pinned to data
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    lock_state_t state;
    logic        sel_data;
    logic        accept;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_head;

    always_comb begin
        sel_data = (state == ST_LOCK_D) || ((state == ST_IDLE) && data_req);
        // Full FIFO stalls the port but leaves the lock untouched.
        mem_req  = (sel_data ? data_req : inst_req) && !fifo_full && !reset;
        accept   = mem_req && mem_addr_ok;

        mem_size  = sel_data ? data_size  : SIZE_WORD;
        mem_wstrb = sel_data ? data_wstrb : 4'h0;
        mem_addr  = sel_data ? data_addr  : inst_addr;
        mem_wdata = sel_data ? data_wdata : 32'h0;

        inst_addr_ok = accept && !sel_data;
        data_addr_ok = accept && sel_data;

        pop          = mem_data_ok && !fifo_empty && !reset;
        inst_data_ok = pop && (fifo_head == OWNER_INST);
        data_data_ok = pop && (fifo_head == OWNER_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state <= sel_data ? ST_LOCK_D : ST_LOCK_I;
                    end
                end
                ST_LOCK_I, ST_LOCK_D: begin
                    if (accept) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sram_arbiter_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (sel_data ? OWNER_DATA : OWNER_INST),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: priority, lock, owner routing, full stall and reset.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [4:0] oks;
    assign oks = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

    always #5 clk = ~clk;

    sram_arbiter #(.OUTSTANDING(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_size   = 2'd0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0000;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        tick();
        tick();
        checks++;
        if (oks !== 5'b00000) begin
            errors++;
            $display("FAIL reset_oks: got %b exp 00000", oks);
        end
        clear_inputs();
        reset = 1'b0;
        tick();
        checks++;
        if (oks !== 5'b00000) begin
            errors++;
            $display("FAIL reset_idle: got %b exp 00000", oks);
        end
    endtask

    task automatic test_inst_only;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0000;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b11000) begin
            errors++;
            $display("FAIL inst_accept_oks: got %b exp 11000", oks);
        end
        checks++;
        if ({mem_addr, mem_size, mem_wstrb, mem_wdata} !== {32'h1c00_0000, 2'b10, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL inst_accept_bus: got %h %b %h %h exp 1c000000 10 0 00000000",
                     mem_addr, mem_size, mem_wstrb, mem_wdata);
        end
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        checks++;
        if (oks !== 5'b00000) begin
            errors++;
            $display("FAIL inst_wait_oks: got %b exp 00000", oks);
        end
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0280_0000;
        #1;
        checks++;
        if (oks !== 5'b00010 || inst_rdata !== 32'h0280_0000) begin
            errors++;
            $display("FAIL inst_resp: got oks %b rdata %h exp 00010 02800000", oks, inst_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_priority;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0004;
        data_req    = 1'b1;
        data_size   = 2'd2;
        data_wstrb  = 4'hf;
        data_addr   = 32'h0000_0100;
        data_wdata  = 32'hdead_beef;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b10100) begin
            errors++;
            $display("FAIL prio_data_first: got %b exp 10100", oks);
        end
        checks++;
        if ({mem_addr, mem_wstrb, mem_wdata} !== {32'h0000_0100, 4'hf, 32'hdead_beef}) begin
            errors++;
            $display("FAIL prio_data_bus: got %h %h %h exp 00000100 f deadbeef",
                     mem_addr, mem_wstrb, mem_wdata);
        end
        tick();
        data_req = 1'b0;
        #1;
        checks++;
        if (oks !== 5'b11000 || {mem_addr, mem_size, mem_wstrb} !== {32'h1c00_0004, 2'b10, 4'h0}) begin
            errors++;
            $display("FAIL prio_inst_next: got %b %h %b %h exp 11000 1c000004 10 0",
                     oks, mem_addr, mem_size, mem_wstrb);
        end
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'haaaa_0001;
        #1;
        checks++;
        if (oks !== 5'b00001 || data_rdata !== 32'haaaa_0001) begin
            errors++;
            $display("FAIL prio_resp_data: got %b %h exp 00001 aaaa0001", oks, data_rdata);
        end
        tick();
        mem_rdata = 32'haaaa_0002;
        #1;
        checks++;
        if (oks !== 5'b00010 || inst_rdata !== 32'haaaa_0002) begin
            errors++;
            $display("FAIL prio_resp_inst: got %b %h exp 00010 aaaa0002", oks, inst_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_lock;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0008;
        #1;
        checks++;
        if (oks !== 5'b10000 || mem_addr !== 32'h1c00_0008) begin
            errors++;
            $display("FAIL lock_stall0: got %b %h exp 10000 1c000008", oks, mem_addr);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            data_req   = 1'b1;
            data_size  = 2'd0;
            data_wstrb = 4'h0;
            data_addr  = 32'h0000_0203;
            #1;
            checks++;
            if (oks !== 5'b10000 || mem_addr !== 32'h1c00_0008 || mem_size !== 2'b10) begin
                errors++;
                $display("FAIL lock_held%0d: got %b %h %b exp 10000 1c000008 10",
                         c, oks, mem_addr, mem_size);
            end
        end
        tick();
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b11000 || mem_addr !== 32'h1c00_0008) begin
            errors++;
            $display("FAIL lock_release: got %b %h exp 11000 1c000008", oks, mem_addr);
        end
        tick();
        inst_req = 1'b0;
        #1;
        checks++;
        if (oks !== 5'b10100 || mem_addr !== 32'h0000_0203 || mem_size !== 2'b00) begin
            errors++;
            $display("FAIL lock_data_after: got %b %h %b exp 10100 00000203 00",
                     oks, mem_addr, mem_size);
        end
        tick();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b00010) begin
            errors++;
            $display("FAIL lock_resp_inst: got %b exp 00010", oks);
        end
        tick();
        #1;
        checks++;
        if (oks !== 5'b00001) begin
            errors++;
            $display("FAIL lock_resp_data: got %b exp 00001", oks);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_full;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0010;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b11000) begin
            errors++;
            $display("FAIL full_acc_inst: got %b exp 11000", oks);
        end
        tick();
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_size  = 2'd1;
        data_wstrb = 4'h0;
        data_addr  = 32'h0000_0300;
        #1;
        checks++;
        if (oks !== 5'b10100) begin
            errors++;
            $display("FAIL full_acc_data: got %b exp 10100", oks);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            data_req  = 1'b0;
            inst_req  = 1'b1;
            inst_addr = 32'h1c00_0014;
            #1;
            checks++;
            if (oks !== 5'b00000) begin
                errors++;
                $display("FAIL full_stall%0d: got %b exp 00000", c, oks);
            end
        end
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        #1;
        checks++;
        if (oks !== 5'b00010 || inst_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL full_pop_inst: got %b %h exp 00010 11111111", oks, inst_rdata);
        end
        tick();
        mem_rdata = 32'h2222_2222;
        #1;
        checks++;
        if (oks !== 5'b11001 || data_rdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL full_push_pop: got %b %h exp 11001 22222222", oks, data_rdata);
        end
        tick();
        inst_req  = 1'b0;
        mem_rdata = 32'h3333_3333;
        #1;
        checks++;
        if (oks !== 5'b00010 || inst_rdata !== 32'h3333_3333) begin
            errors++;
            $display("FAIL full_third_resp: got %b %h exp 00010 33333333", oks, inst_rdata);
        end
        tick();
        #1;
        checks++;
        if (oks !== 5'b00000) begin
            errors++;
            $display("FAIL empty_stray: got %b exp 00000", oks);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_outstanding;
        data_req    = 1'b1;
        data_wstrb  = 4'h3;
        data_size   = 2'd1;
        data_addr   = 32'h0000_0400;
        mem_addr_ok = 1'b1;
        tick();
        data_req  = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h1c00_0020;
        tick();
        reset       = 1'b1;
        data_req    = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b00000) begin
            errors++;
            $display("FAIL rst_out_oks: got %b exp 00000", oks);
        end
        tick();
        reset       = 1'b0;
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        checks++;
        if (oks !== 5'b00000) begin
            errors++;
            $display("FAIL rst_stray: got %b exp 00000", oks);
        end
        tick();
        mem_data_ok = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0024;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b11000) begin
            errors++;
            $display("FAIL rst_fresh_acc: got %b exp 11000", oks);
        end
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (oks !== 5'b00010) begin
            errors++;
            $display("FAIL rst_fresh_resp: got %b exp 00010", oks);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_inst_only();
        test_priority();
        test_lock();
        test_full();
        test_reset_outstanding();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
